// File: rtl/sprite_pkg.sv
// ============================================================================
// Module   : sprite_pkg
// Purpose  : Shared widths, types and animation state encoding for the
//            sprite address generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

    localparam int ADDR_W  = 14;
    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [ADDR_W-1:0]  rom_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } anim_state_t;

endpackage : sprite_pkg

`default_nettype wire

// File: rtl/anim_seq.sv
// ============================================================================
// Module   : anim_seq
// Purpose  : Vsync-paced animation sequencer. Holds each frame for HOLD
//            frame_start pulses, then advances, wraps (LOOP=1) or stops on
//            the last frame with a one-cycle anim_done pulse (LOOP=0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module anim_seq
    import sprite_pkg::*;
#(
    parameter int FRAMES  = 4,
    parameter int HOLD    = 6,
    parameter int LOOP    = 0,
    parameter int FRAME_W = 2
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               anim_start,
    output logic [FRAME_W-1:0] frame,
    output logic               anim_busy,
    output logic               anim_done
);

    localparam logic [3:0]         TICK_LAST  = 4'(HOLD - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);

    anim_state_t        state_q, state_d;
    logic [3:0]         tick_q,  tick_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               done_q,  done_d;

    // Next-state: a start pulse always wins and restarts from frame 0;
    // otherwise frame_start paces the hold counter while playing.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        frame_d = frame_q;
        done_d  = 1'b0;

        if (anim_start) begin
            state_d = PLAY;
            tick_d  = 4'd0;
            frame_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    frame_d = '0;
                end
                PLAY: begin
                    if (frame_start) begin
                        if (tick_q == TICK_LAST) begin
                            tick_d = 4'd0;
                            if (frame_q != FRAME_LAST) begin
                                frame_d = frame_q + 1'b1;
                            end else if (LOOP == 1) begin
                                frame_d = '0;
                            end else begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            tick_d = tick_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    frame_d = FRAME_LAST;
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = 4'd0;
                    frame_d = '0;
                end
            endcase
        end
    end

    // State register; reset abandons any animation without a done pulse.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tick_q  <= 4'd0;
            frame_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    assign frame     = frame_q;
    assign anim_busy = (state_q == PLAY);
    assign anim_done = done_q;

endmodule : anim_seq

`default_nettype wire

// File: rtl/sprite_addr_gen.sv
// ============================================================================
// Module   : sprite_addr_gen
// Purpose  : Maps the VGA draw coordinate onto one sprite's bounding box and
//            registers the 14-bit frame-ROM address with an in-box qualifier.
//            The animation frame selects which stacked image is addressed.
// Config   : SPRITE_MIRROR_EN - when defined, facing=1 mirrors the column.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int SPR_W  = 64,
    parameter int SPR_H  = 64,
    parameter int FRAMES = 4,
    parameter int HOLD   = 6,
    parameter int LOOP   = 0
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic              facing,
    input  logic              frame_start,
    input  logic              anim_start,
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_on,
    output logic              anim_busy,
    output logic              anim_done
);

    localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic [FRAME_W-1:0] w_frame;

    anim_seq #(
        .FRAMES  (FRAMES),
        .HOLD    (HOLD),
        .LOOP    (LOOP),
        .FRAME_W (FRAME_W)
    ) u_anim_seq (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .anim_start  (anim_start),
        .frame       (w_frame),
        .anim_busy   (anim_busy),
        .anim_done   (anim_done)
    );

    // 11-bit two's-complement offsets; a set sign bit means left of / above
    // the sprite, which also covers sprites parked off-screen to the right.
    logic [COORD_W:0]   w_rel_x;
    logic [COORD_W:0]   w_rel_y;
    logic               w_in_box;
    coord_t             w_col;

    assign w_rel_x  = {1'b0, draw_x} - {1'b0, pos_x};
    assign w_rel_y  = {1'b0, draw_y} - {1'b0, pos_y};
    assign w_in_box = !w_rel_x[COORD_W] && (w_rel_x[COORD_W-1:0] < COORD_W'(SPR_W)) &&
                      !w_rel_y[COORD_W] && (w_rel_y[COORD_W-1:0] < COORD_W'(SPR_H));

`ifdef SPRITE_MIRROR_EN
    assign w_col = facing ? (COORD_W'(SPR_W - 1) - w_rel_x[COORD_W-1:0])
                          : w_rel_x[COORD_W-1:0];
`else
    logic w_unused_facing;
    assign w_unused_facing = facing;
    assign w_col           = w_rel_x[COORD_W-1:0];
`endif

    rom_addr_t rom_address_d, rom_address_q;
    logic      sprite_on_d,   sprite_on_q;

    // Address = frame base + row base + column; the multiplies are by
    // power-of-two constants for the default geometry.
    always_comb begin
        rom_address_d = '0;
        sprite_on_d   = 1'b0;
        if (w_in_box) begin
            sprite_on_d   = 1'b1;
            rom_address_d = ADDR_W'(w_frame) * ADDR_W'(SPR_W * SPR_H)
                          + ADDR_W'(w_rel_y[COORD_W-1:0]) * ADDR_W'(SPR_W)
                          + ADDR_W'(w_col);
        end
    end

    // Output registers: address and qualifier stay cycle-aligned.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            rom_address_q <= '0;
            sprite_on_q   <= 1'b0;
        end else begin
            rom_address_q <= rom_address_d;
            sprite_on_q   <= sprite_on_d;
        end
    end

    assign rom_address = rom_address_q;
    assign sprite_on   = sprite_on_q;

endmodule : sprite_addr_gen

`default_nettype wire

// File: tb/tb_sprite_addr_gen.sv
// ============================================================================
// Module   : tb_sprite_addr_gen
// Purpose  : Directed self-checking bench for sprite_addr_gen with one
//            non-looping and one looping instance sharing the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_addr_gen;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  draw_x, draw_y, pos_x, pos_y;
    logic        facing, frame_start, anim_start;

    logic [13:0] rom0, rom1;
    logic        on0, on1, busy0, busy1, done0, done1;

    int errors = 0;
    int checks = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_addr_gen #(.SPR_W(64), .SPR_H(64), .FRAMES(4), .HOLD(6), .LOOP(0)) dut0 (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .draw_x(draw_x), .draw_y(draw_y), .pos_x(pos_x), .pos_y(pos_y),
        .facing(facing), .frame_start(frame_start), .anim_start(anim_start),
        .rom_address(rom0), .sprite_on(on0), .anim_busy(busy0), .anim_done(done0)
    );

    sprite_addr_gen #(.SPR_W(64), .SPR_H(64), .FRAMES(4), .HOLD(6), .LOOP(1)) dut1 (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .draw_x(draw_x), .draw_y(draw_y), .pos_x(pos_x), .pos_y(pos_y),
        .facing(facing), .frame_start(frame_start), .anim_start(anim_start),
        .rom_address(rom1), .sprite_on(on1), .anim_busy(busy1), .anim_done(done1)
    );

    // Count every anim_done cycle, sampled mid-cycle.
    always @(negedge vga_clk) begin
        if (done0) done0_cnt++;
        if (done1) done1_cnt++;
    end

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pulse_frame(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_mirror;
`ifdef SPRITE_MIRROR_EN
        exp_mirror = 245;
`else
        exp_mirror = 202;
`endif
        reset_n = 1'b0; facing = 1'b0; frame_start = 1'b0; anim_start = 1'b0;
        pos_x = 10'd100; pos_y = 10'd50; draw_x = 10'd100; draw_y = 10'd50;
        tick(); tick();
        check("reset_rom",  32'(rom0),  0);
        check("reset_on",   32'(on0),   0);
        check("reset_busy", 32'(busy0), 0);
        check("reset_done", 32'(done0), 0);

        reset_n = 1'b1;
        tick();
        check("release_rom", 32'(rom0), 0);
        check("release_on",  32'(on0),  1);

        draw_x = 10'd110; draw_y = 10'd53;
        tick();
        check("idle_rom_202", 32'(rom0), 202);
        check("idle_on",      32'(on0),  1);

        draw_x = 10'd164; draw_y = 10'd50;
        tick();
        check("right_edge_on",  32'(on0),  0);
        check("right_edge_rom", 32'(rom0), 0);

        draw_x = 10'd163;
        tick();
        check("last_col_rom", 32'(rom0), 63);

        facing = 1'b1; draw_x = 10'd110; draw_y = 10'd53;
        tick();
        check("mirror_rom", 32'(rom0), 32'(exp_mirror));
        facing = 1'b0;

        pos_x = 10'd1000; draw_x = 10'd5;
        tick();
        check("offscreen_on",  32'(on0),  0);
        check("offscreen_rom", 32'(rom0), 0);

        pos_x = 10'd100; draw_x = 10'd100; draw_y = 10'd50;
        tick();
        check("idle_noframe_advance_pre", 32'(rom0), 0);
        pulse_frame(6);
        check("idle_noframe_advance", 32'(rom0), 0);

        anim_start = 1'b1;
        tick();
        anim_start = 1'b0;
        check("start_busy0", 32'(busy0), 1);
        check("start_busy1", 32'(busy1), 1);
        check("start_rom",   32'(rom0),  0);

        pulse_frame(5);
        check("hold5_rom", 32'(rom0), 0);
        pulse_frame(1);
        check("frame1_rom", 32'(rom0), 4096);
        pulse_frame(12);
        check("frame3_rom", 32'(rom0), 12288);
        pulse_frame(5);
        check("pre_done_busy", 32'(busy0), 1);
        check("pre_done_cnt",  32'(done0_cnt), 0);

        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("done_pulse",  32'(done0), 1);
        check("done_busy0",  32'(busy0), 0);
        check("loop_done1",  32'(done1), 0);
        check("loop_busy1",  32'(busy1), 1);
        tick();
        check("done_cleared", 32'(done0), 0);
        check("done_rom",     32'(rom0),  12288);
        check("loop_rom",     32'(rom1),  0);

        pulse_frame(6);
        check("done_hold_rom", 32'(rom0), 12288);
        check("done0_count",   32'(done0_cnt), 1);
        check("done1_count",   32'(done1_cnt), 0);
        check("loop_frame1",   32'(rom1), 4096);

        pulse_frame(1);
        anim_start = 1'b1; frame_start = 1'b1;
        tick();
        anim_start = 1'b0; frame_start = 1'b0;
        tick();
        check("restart_rom0",  32'(rom0),  0);
        check("restart_rom1",  32'(rom1),  0);
        check("restart_busy0", 32'(busy0), 1);
        pulse_frame(5);
        check("coincident_tick0", 32'(rom1), 0);
        pulse_frame(1);
        check("coincident_frame1", 32'(rom1), 4096);
        pulse_frame(6);
        check("frame2_rom0", 32'(rom0), 8192);
        check("frame2_rom1", 32'(rom1), 8192);

        reset_n = 1'b0;
        tick();
        check("midreset_busy", 32'(busy0), 0);
        check("midreset_done", 32'(done0), 0);
        check("midreset_rom",  32'(rom0),  0);
        check("midreset_on",   32'(on0),   0);
        reset_n = 1'b1;
        tick();
        check("postreset_rom",  32'(rom0),  0);
        check("postreset_on",   32'(on0),   1);
        check("postreset_busy", 32'(busy1), 0);
        tick();
        check("postreset_done_cnt", 32'(done0_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sprite_addr_gen

`default_nettype wire
